speed_display: RTL and testbench

SPEED_DISPLAY -- requirements
Module: speed_display

---
 rtl/speed_display_pkg.sv | 27 ++
 rtl/speed_display_seg7_decoder.sv | 26 ++
 rtl/speed_display.sv | 154 +++++++++++++++
 tb/tb_speed_display.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/speed_display_pkg.sv
// Shared types and seven-segment constants for the speed display.
package speed_display_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int unsigned CNT_W      = 32;
    localparam int unsigned BIN_W      = 16;
    localparam int unsigned BCD_DIGITS = 5;
    localparam int unsigned BCD_W      = 20;

    // Active-low patterns, seg[7] = dp (off)
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_D0    = 8'hC0;
    localparam logic [7:0] SEG_D1    = 8'hF9;
    localparam logic [7:0] SEG_D2    = 8'hA4;
    localparam logic [7:0] SEG_D3    = 8'hB0;
    localparam logic [7:0] SEG_D4    = 8'h99;
    localparam logic [7:0] SEG_D5    = 8'h92;
    localparam logic [7:0] SEG_D6    = 8'h82;
    localparam logic [7:0] SEG_D7    = 8'hF8;
    localparam logic [7:0] SEG_D8    = 8'h80;
    localparam logic [7:0] SEG_D9    = 8'h90;

endpackage

// File: rtl/speed_display_seg7_decoder.sv
// BCD digit to active-low a..g segment pattern; non-decimal codes go blank.
module seg7_decoder
    import speed_display_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [6:0]  seg_c
);

    always_comb begin
        seg_c = SEG_BLANK[6:0];
        case (digit)
            4'd0:    seg_c = SEG_D0[6:0];
            4'd1:    seg_c = SEG_D1[6:0];
            4'd2:    seg_c = SEG_D2[6:0];
            4'd3:    seg_c = SEG_D3[6:0];
            4'd4:    seg_c = SEG_D4[6:0];
            4'd5:    seg_c = SEG_D5[6:0];
            4'd6:    seg_c = SEG_D6[6:0];
            4'd7:    seg_c = SEG_D7[6:0];
            4'd8:    seg_c = SEG_D8[6:0];
            4'd9:    seg_c = SEG_D9[6:0];
            default: seg_c = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/speed_display.sv
// Periodically samples a binary speed, converts it to BCD by double-dabble,
// and multiplexes four seven-segment digits with leading-zero blanking.
module speed_display
    import speed_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 5000,
    parameter int unsigned UPDATE_DIV = 5000000
) (
    input  logic              clk0,
    input  logic              rst,
    input  logic [BIN_W-1:0]  speed,
    output logic [7:0]        seg,
    output logic [3:0]        an
);

    logic [CNT_W-1:0] upd_cnt;
    logic [CNT_W-1:0] scan_cnt;
    logic [CNT_W-1:0] shift_cnt;
    logic [BIN_W-1:0] sr_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] disp_q;
    logic [1:0]       digit_idx;
    state_t           state_q;
    state_t           state_d;
    logic             tick_c;
    logic             scan_wrap_c;
    logic             load_c;
    logic             shift_c;
    logic             done_c;

    assign tick_c      = (upd_cnt == CNT_W'(UPDATE_DIV - 1));
    assign scan_wrap_c = (scan_cnt == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk0) begin
        if (rst)         upd_cnt <= '0;
        else if (tick_c) upd_cnt <= '0;
        else             upd_cnt <= upd_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk0) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        shift_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE:  if (tick_c) state_d = LOAD;
            LOAD:  begin
                load_c  = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_c = 1'b1;
                if (shift_cnt == CNT_W'(BIN_W - 1)) state_d = DONE;
            end
            DONE:  begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Double-dabble correction: any digit >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd_q[(i << 2) +: 4] >= 4'd5)
                bcd_adj[(i << 2) +: 4] = bcd_q[(i << 2) +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            sr_q      <= '0;
            bcd_q     <= '0;
            shift_cnt <= '0;
            disp_q    <= '0;
        end else begin
            if (load_c) begin
                sr_q      <= speed;
                bcd_q     <= '0;
                shift_cnt <= '0;
            end else if (shift_c) begin
                bcd_q     <= {bcd_adj[BCD_W-2:0], sr_q[BIN_W-1]};
                sr_q      <= {sr_q[BIN_W-2:0], 1'b0};
                shift_cnt <= shift_cnt + CNT_W'(1);
            end
            if (done_c) disp_q <= bcd_q;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_wrap_c) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + CNT_W'(1);
        end
    end

    bcd_digit_t  digit_c;
    logic        blank_c;
    logic        overflow_c;
    logic [6:0]  dec_seg_c;
    logic [7:0]  seg_d;
    logic [3:0]  an_d;

    // A digit blanks only when it and every digit above it are zero
    always_comb begin
        digit_c = disp_q[3:0];
        blank_c = 1'b0;
        case (digit_idx)
            2'd0: begin digit_c = disp_q[3:0];   blank_c = 1'b0;                   end
            2'd1: begin digit_c = disp_q[7:4];   blank_c = (disp_q[15:4] == '0);  end
            2'd2: begin digit_c = disp_q[11:8];  blank_c = (disp_q[15:8] == '0);  end
            2'd3: begin digit_c = disp_q[15:12]; blank_c = (disp_q[15:12] == '0); end
            default: ;
        endcase
    end

    assign overflow_c = (disp_q[19:16] != 4'd0);

    seg7_decoder u_dec (
        .digit (digit_c),
        .seg_c (dec_seg_c)
    );

    always_comb begin
        seg_d = {1'b1, dec_seg_c};
        if (overflow_c)   seg_d = SEG_DASH;
        else if (blank_c) seg_d = SEG_BLANK;
        an_d = ~(4'b0001 << digit_idx);
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= 4'hF;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_speed_display.sv
// Directed bench for speed_display with SCAN_DIV=4, UPDATE_DIV=64.
module tb_speed_display;
    import speed_display_pkg::*;

    logic        clk0;
    logic        rst;
    logic [15:0] speed;
    logic [7:0]  seg;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;
    int t      = 0;

    speed_display #(.SCAN_DIV(4), .UPDATE_DIV(64)) dut (
        .clk0  (clk0),
        .rst   (rst),
        .speed (speed),
        .seg   (seg),
        .an    (an)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk0);
            t = t + 1;
        end
        #1;
    endtask

    task automatic go_to(input int target);
        adv(target - t);
    endtask

    task automatic scan(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3);
        logic [3:0] seen;
        logic [7:0] ex;
        seen = 4'h0;
        for (int i = 0; i < 16; i++) begin
            adv(1);
            case (an)
                4'hE: begin ex = e0; seen[0] = 1'b1; end
                4'hD: begin ex = e1; seen[1] = 1'b1; end
                4'hB: begin ex = e2; seen[2] = 1'b1; end
                4'h7: begin ex = e3; seen[3] = 1'b1; end
                default: ex = 8'hxx;
            endcase
            chk(tag, 32'(seg), 32'(ex));
        end
        chk({tag, " digits"}, 32'(seen), 32'hF);
    endtask

    initial begin
        rst   = 1'b1;
        speed = 16'd0;

        // Reset held 10 cycles
        repeat (3) @(posedge clk0);
        #1;
        chk("rst seg", 32'(seg), 32'hFF);
        chk("rst an",  32'(an),  32'hF);
        repeat (7) @(posedge clk0);
        #1;
        chk("rst seg end", 32'(seg), 32'hFF);
        chk("rst an end",  32'(an),  32'hF);
        chk("rst state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        t   = 0;

        // Scan order and the "0" idle display
        adv(1);
        chk("an t1",  32'(an),  32'hE);
        chk("seg t1", 32'(seg), 32'hC0);
        go_to(4);  chk("an t4",  32'(an), 32'hE);
        go_to(5);  chk("an t5",  32'(an), 32'hD);
        chk("seg t5", 32'(seg), 32'hFF);
        go_to(9);  chk("an t9",  32'(an), 32'hB);
        go_to(13); chk("an t13", 32'(an), 32'h7);
        go_to(17); chk("an t17", 32'(an), 32'hE);
        go_to(20);
        scan("zero", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        // 1234: tick at 64, display changes at 82
        speed = 16'd1234;
        go_to(81); chk("lat pre 1234",  32'(dut.disp_q), 32'h00000);
        go_to(82); chk("lat post 1234", 32'(dut.disp_q), 32'h01234);
        go_to(84);
        scan("1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        speed = 16'd7;
        go_to(150);
        scan("7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);

        speed = 16'd1000;
        go_to(212);
        scan("1000", 8'hC0, 8'hC0, 8'hC0, 8'hF9);

        speed = 16'd10000;
        go_to(276);
        scan("10000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

        speed = 16'd65535;
        go_to(340);
        scan("65535", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

        // speed changes during SHIFT must not disturb the conversion
        speed = 16'd1234;
        go_to(390);
        chk("state shift", 32'(dut.state_q), 32'(SHIFT));
        speed = 16'd9999;
        go_to(401); chk("lat pre mid", 32'(dut.disp_q), 32'h65535);
        go_to(402); chk("lat post mid", 32'(dut.disp_q), 32'h01234);
        go_to(404);
        scan("1234 held", 8'h99, 8'hB0, 8'hA4, 8'hF9);
        go_to(466); chk("disp 9999", 32'(dut.disp_q), 32'h09999);
        go_to(468);
        scan("9999", 8'h90, 8'h90, 8'h90, 8'h90);

        // Reset pulse mid-SHIFT aborts conversion
        speed = 16'd1234;
        go_to(532); chk("disp 1234 again", 32'(dut.disp_q), 32'h01234);
        speed = 16'd5678;
        go_to(585); chk("state shift2", 32'(dut.state_q), 32'(SHIFT));
        rst = 1'b1;
        adv(1);
        chk("pulse seg",   32'(seg), 32'hFF);
        chk("pulse an",    32'(an),  32'hF);
        chk("pulse state", 32'(dut.state_q), 32'(IDLE));
        chk("pulse disp",  32'(dut.disp_q), 32'h00000);
        rst = 1'b0;
        t   = 0;
        adv(1);
        chk("post rst an",  32'(an),  32'hE);
        chk("post rst seg", 32'(seg), 32'hC0);
        go_to(81); chk("lat pre 5678",  32'(dut.disp_q), 32'h00000);
        go_to(82); chk("lat post 5678", 32'(dut.disp_q), 32'h05678);
        go_to(84);
        scan("5678", 8'h80, 8'hF8, 8'h82, 8'h92);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
